strobe_arbiter: RTL and testbench

//  Source-domain scheduler that shares one strobe/toggle clock-crossing channel among N requesters.
//  - Arbitrates round-robin between requesters and stamps each word with a requester id.
//  - Issues a one-cycle strobe plus held data into the crossing.
//  - Enforces a minimum strobe spacing so the crossing's data register is not overwritten before
//    the slow domain samples it.
//  - Optionally waits for a returned ack strobe, with a timeout.

---
 rtl/strobe_arbiter_pkg.sv | 16 +
 rtl/strobe_arbiter_if.sv | 24 ++
 rtl/strobe_arbiter_rr.sv | 43 ++++
 rtl/strobe_arbiter.sv | 115 +++++++++++
 tb/tb_strobe_arbiter.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/strobe_arbiter_pkg.sv
// Shared types and helpers for the strobe arbiter.
// FSM state encoding and counter-width helper.
package strobe_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_HOLD     = 2'd1,
        ST_WAIT_ACK = 2'd2
    } state_e;

    // clog2 that never yields a zero-width vector
    function automatic int cw(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/strobe_arbiter_if.sv
// Request/crossing bundle between requesters, arbiter and the CDC channel.
// master = arbiter side, slave = requesters plus crossing.
interface strobe_arbiter_if #(
    parameter int N     = 4,
    parameter int WIDTH = 8,
    parameter int IDW   = 2
);
    logic [N-1:0]         req_valid;
    logic [N*WIDTH-1:0]   req_data;
    logic [N-1:0]         req_ready;
    logic                 xfer_strobe;
    logic [IDW+WIDTH-1:0] xfer_data;
    logic                 ack_strobe;

    modport master (
        input  req_valid, req_data, ack_strobe,
        output req_ready, xfer_strobe, xfer_data
    );

    modport slave (
        output req_valid, req_data, ack_strobe,
        input  req_ready, xfer_strobe, xfer_data
    );
endinterface

// File: rtl/strobe_arbiter_rr.sv
// Round-robin arbiter: one-hot grant, first valid at or after the pointer.
// The pointer moves past the winner only when the grant is taken.
module rr_arbiter
    import strobe_arbiter_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [N-1:0]  req,
    input  logic          enable,
    input  logic          advance,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx
);
    logic [IW-1:0] ptr_q;
    logic [IW-1:0] ptr_d;
    logic          found;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!found && enable && req[(int'(ptr_q) + k) % N]) begin
                grant[(int'(ptr_q) + k) % N] = 1'b1;
                idx   = IW'((int'(ptr_q) + k) % N);
                found = 1'b1;
            end
        end
    end

    assign ptr_d = IW'((int'(idx) + 1) % N);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q <= '0;
        end else if (advance) begin
            ptr_q <= ptr_d;
        end
    end
endmodule

// File: rtl/strobe_arbiter.sv
// Source-domain scheduler sharing one strobe/toggle crossing among N requesters.
// Spaces strobes by GAP+1 cycles and optionally waits for a returned ack.
module strobe_arbiter
    import strobe_arbiter_pkg::*;
#(
    parameter int N       = 4,
    parameter int WIDTH   = 8,
    parameter int IDW     = 2,
    parameter int GAP     = 8,
    parameter int USE_ACK = 0,
    parameter int TIMEOUT = 64
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            enable,
    strobe_arbiter_if.master bus,
    output logic            busy,
    output logic            timeout_err
);
    localparam int CW = cw(GAP + 1);
    localparam int TW = cw(TIMEOUT + 1);

    state_e               state_q;
    logic [CW-1:0]        cnt_q;
    logic [TW-1:0]        tcnt_q;
    logic                 ack_seen_q;
    logic                 strobe_q;
    logic                 terr_q;
    logic [IDW+WIDTH-1:0] data_q;

    logic [N-1:0]   grant;
    logic [IDW-1:0] idx;
    logic [WIDTH-1:0] payload;
    logic           ack;
    logic           accept;

    rr_arbiter #(.N(N), .IW(IDW)) u_rr (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (bus.req_valid),
        .enable  (enable && (state_q == ST_IDLE)),
        .advance (accept),
        .grant   (grant),
        .idx     (idx)
    );

    assign accept = |grant;
    assign ack    = (USE_ACK != 0) && bus.ack_strobe;

    always_comb begin
        payload = '0;
        for (int k = 0; k < N; k++) begin
            if (grant[k]) payload = bus.req_data[k*WIDTH +: WIDTH];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            tcnt_q     <= '0;
            ack_seen_q <= 1'b0;
            strobe_q   <= 1'b0;
            terr_q     <= 1'b0;
            data_q     <= '0;
        end else begin
            strobe_q <= 1'b0;
            terr_q   <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        data_q     <= {idx, payload};
                        strobe_q   <= 1'b1;
                        cnt_q      <= CW'(GAP - 1);
                        ack_seen_q <= 1'b0;
                        state_q    <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (cnt_q == '0) begin
                        ack_seen_q <= 1'b0;
                        tcnt_q     <= '0;
                        // an ack already seen lets us skip WAIT_ACK entirely
                        if ((USE_ACK != 0) && !(ack_seen_q || ack))
                            state_q <= ST_WAIT_ACK;
                        else
                            state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                        if (ack) ack_seen_q <= 1'b1;
                    end
                end
                ST_WAIT_ACK: begin
                    if (ack || ack_seen_q) begin
                        ack_seen_q <= 1'b0;
                        state_q    <= ST_IDLE;
                    end else if ((TIMEOUT != 0) &&
                                 (tcnt_q == TW'(TIMEOUT - 1))) begin
                        terr_q  <= 1'b1;
                        state_q <= ST_IDLE;
                    end else begin
                        tcnt_q <= tcnt_q + 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.req_ready   = grant;
    assign bus.xfer_strobe = strobe_q;
    assign bus.xfer_data   = data_q;
    assign busy            = (state_q != ST_IDLE);
    assign timeout_err     = terr_q;
endmodule

// File: tb/tb_strobe_arbiter.sv
// Directed bench for strobe_arbiter: a no-ack instance and an ack/timeout
// instance, with a queue of expected {id,payload} words checked on each strobe.
module tb_strobe_arbiter;

    logic clk = 1'b0;
    logic reset_n;
    logic en;
    logic busy0, terr0, busy1, terr1;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [9:0] sbq[$];

    strobe_arbiter_if #(.N(4), .WIDTH(8), .IDW(2)) if0 ();
    strobe_arbiter_if #(.N(4), .WIDTH(8), .IDW(2)) if1 ();

    strobe_arbiter #(
        .N(4), .WIDTH(8), .IDW(2), .GAP(8), .USE_ACK(0), .TIMEOUT(64)
    ) u0 (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable      (en),
        .bus         (if0),
        .busy        (busy0),
        .timeout_err (terr0)
    );

    strobe_arbiter #(
        .N(4), .WIDTH(8), .IDW(2), .GAP(8), .USE_ACK(1), .TIMEOUT(64)
    ) u1 (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable      (en),
        .bus         (if1),
        .busy        (busy1),
        .timeout_err (terr1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic str(input bit d);
        return d ? if1.xfer_strobe : if0.xfer_strobe;
    endfunction

    function automatic logic [9:0] xd(input bit d);
        return d ? if1.xfer_data : if0.xfer_data;
    endfunction

    // advance at least one cycle, then wait for a strobe and score its word
    task automatic wait_word(input bit d, output int at);
        logic [9:0] e;
        int n;
        n = 0;
        tick();
        while (!str(d) && n < 100) begin
            tick();
            n++;
        end
        at = cyc;
        chk("strobe_seen", 32'(str(d)), 32'd1);
        e = (sbq.size() > 0) ? sbq.pop_front() : 10'bx;
        chk("word", 32'(xd(d)), 32'(e));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=stuck expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, ta, tb, tc, t4, t5, t6;
        int ts[5];

        reset_n = 1'b0;
        en = 1'b1;
        if0.req_valid = '0; if0.req_data = '0; if0.ack_strobe = 1'b0;
        if1.req_valid = '0; if1.req_data = '0; if1.ack_strobe = 1'b0;
        tick(2);
        chk("rst_strobe", 32'(if0.xfer_strobe), 32'd0);
        chk("rst_data",   32'(if0.xfer_data),   32'd0);
        chk("rst_busy",   32'(busy0),           32'd0);
        chk("rst_terr",   32'(terr0),           32'd0);
        chk("rst_ready",  32'(if0.req_ready),   32'd0);
        reset_n = 1'b1;
        tick();

        // single word from requester 0
        if0.req_data = {8'h00, 8'h00, 8'h00, 8'hA5};
        if0.req_valid = 4'b0001;
        #1;
        chk("t1_ready", 32'(if0.req_ready), 32'h1);
        sbq.push_back({2'd0, 8'hA5});
        c0 = cyc;
        wait_word(0, ta);
        chk("t1_lat", 32'(ta - c0), 32'd1);
        if0.req_valid = '0;
        tick();
        chk("t1_pulse", 32'(if0.xfer_strobe), 32'd0);
        chk("t1_hold",  32'(if0.xfer_data),   32'({2'd0, 8'hA5}));
        chk("t1_busy",  32'(busy0),           32'd1);

        // all four requesting: 0,1,2,3,0 at 9-cycle spacing
        reset_n = 1'b0;
        if0.req_data = {8'h13, 8'h12, 8'h11, 8'h10};
        if0.req_valid = 4'b1111;
        #1;
        reset_n = 1'b1;
        sbq.push_back({2'd0, 8'h10});
        sbq.push_back({2'd1, 8'h11});
        sbq.push_back({2'd2, 8'h12});
        sbq.push_back({2'd3, 8'h13});
        sbq.push_back({2'd0, 8'h10});
        for (int i = 0; i < 5; i++) begin
            wait_word(0, ts[i]);
            if (i == 0) chk("t2_hold_ready", 32'(if0.req_ready), 32'd0);
            if (i > 0)  chk("t2_gap", 32'(ts[i] - ts[i-1]), 32'd9);
        end
        if0.req_valid = '0;

        // enable low in IDLE blocks grants
        en = 1'b0;
        tick(10);
        if0.req_data = {8'h00, 8'h66, 8'h00, 8'h00};
        if0.req_valid = 4'b0100;
        #1;
        chk("en_block_ready", 32'(if0.req_ready), 32'd0);
        tick(5);
        chk("en_block_strobe", 32'(if0.xfer_strobe), 32'd0);
        chk("en_block_busy",   32'(busy0),           32'd0);
        en = 1'b1;
        #1;
        chk("en_ready", 32'(if0.req_ready), 32'h4);
        sbq.push_back({2'd2, 8'h66});
        wait_word(0, ta);
        if0.req_valid = '0;

        // early ack during HOLD: next accept 9 cycles after the first
        if1.req_data = {8'h00, 8'h00, 8'h3C, 8'h5A};
        if1.req_valid = 4'b0010;
        #1;
        chk("t3_ready", 32'(if1.req_ready), 32'h2);
        sbq.push_back({2'd1, 8'h3C});
        c0 = cyc;
        wait_word(1, ta);
        chk("t3_lat", 32'(ta - c0), 32'd1);
        if1.req_valid = '0;
        tick(2);
        if1.ack_strobe = 1'b1;
        tick();
        if1.ack_strobe = 1'b0;
        if1.req_valid = 4'b0001;
        sbq.push_back({2'd0, 8'h5A});
        wait_word(1, tb);
        chk("t3_next", 32'(tb - ta), 32'd9);
        if1.req_valid = '0;

        // no ack: timeout 64 cycles after WAIT_ACK entry
        c0 = 0;
        while (!terr1 && c0 < 200) begin
            tick();
            c0++;
        end
        tc = cyc;
        chk("t4_terr", 32'(terr1), 32'd1);
        chk("t4_time", 32'(tc - tb), 32'd72);
        if1.req_data = {8'h00, 8'h77, 8'h00, 8'h00};
        if1.req_valid = 4'b0100;
        #1;
        chk("t4_ready", 32'(if1.req_ready), 32'h4);
        sbq.push_back({2'd2, 8'h77});
        wait_word(1, t4);
        chk("t4_once", 32'(terr1), 32'd0);
        chk("t4_next", 32'(t4 - tc), 32'd1);
        if1.req_valid = '0;

        // ack in the same cycle as the timeout wins
        if1.req_data = {8'h99, 8'h00, 8'h00, 8'h00};
        if1.req_valid = 4'b1000;
        sbq.push_back({2'd3, 8'h99});
        wait_word(1, t5);
        if1.req_valid = '0;
        while (cyc < t5 + 71) tick();
        if1.ack_strobe = 1'b1;
        tick();
        if1.ack_strobe = 1'b0;
        chk("t5_noerr", 32'(terr1), 32'd0);
        chk("t5_idle",  32'(busy1), 32'd0);

        // ack in IDLE is ignored; next WAIT_ACK still waits
        tick(2);
        if1.ack_strobe = 1'b1;
        tick();
        if1.ack_strobe = 1'b0;
        if1.req_data = {8'h00, 8'h00, 8'h00, 8'h42};
        if1.req_valid = 4'b0001;
        sbq.push_back({2'd0, 8'h42});
        wait_word(1, t6);
        if1.req_valid = '0;
        while (cyc < t6 + 20) tick();
        chk("t5_waits", 32'(busy1), 32'd1);
        chk("t5_waits_err", 32'(terr1), 32'd0);
        if1.ack_strobe = 1'b1;
        tick();
        if1.ack_strobe = 1'b0;
        chk("t5_acked", 32'(busy1), 32'd0);

        // reset during HOLD
        if0.req_data = {8'h00, 8'h00, 8'h00, 8'h11};
        if0.req_valid = 4'b0001;
        sbq.push_back({2'd0, 8'h11});
        wait_word(0, ta);
        if0.req_valid = '0;
        tick(2);
        reset_n = 1'b0;
        #1;
        chk("t6_hold_busy",   32'(busy0),           32'd0);
        chk("t6_hold_strobe", 32'(if0.xfer_strobe), 32'd0);
        chk("t6_hold_data",   32'(if0.xfer_data),   32'd0);
        chk("t6_hold_terr",   32'(terr0),           32'd0);
        tick();
        reset_n = 1'b1;

        // reset while the strobe is high
        if0.req_data = {8'h00, 8'h00, 8'h00, 8'h22};
        if0.req_valid = 4'b0001;
        sbq.push_back({2'd0, 8'h22});
        wait_word(0, ta);
        if0.req_valid = '0;
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6_stb_strobe", 32'(if0.xfer_strobe), 32'd0);
        chk("t6_stb_data",   32'(if0.xfer_data),   32'd0);
        tick();
        if0.req_data = {8'h44, 8'h00, 8'h00, 8'h33};
        if0.req_valid = 4'b1001;
        reset_n = 1'b1;
        #1;
        chk("t6_prio", 32'(if0.req_ready), 32'h1);
        sbq.push_back({2'd0, 8'h33});
        wait_word(0, ta);
        if0.req_valid = '0;

        chk("sb_empty", 32'(sbq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
